// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and sizing helpers
package uart_pkg;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_RD,
    DS_RDW,
    DS_SEND,
    DS_GAP,
    DS_CKS,
    DS_CKSGAP,
    DS_DONE
  } dump_state_t;

  localparam int DUMP_XLEN_DEFAULT = 32;

  // Bytes per RAM word
  function automatic int dump_bytes(input int xlen);
    return xlen / 8;
  endfunction

  // Byte-index width; at least one bit so single-byte words still have a counter
  function automatic int dump_bidx_w(input int xlen);
    return (xlen / 8 > 1) ? $clog2(xlen / 8) : 1;
  endfunction

  localparam int DUMP_BYTES  = dump_bytes(DUMP_XLEN_DEFAULT);
  localparam int DUMP_BIDX_W = dump_bidx_w(DUMP_XLEN_DEFAULT);

endpackage

// File: rtl/uart_ram_dumper.sv
// rtl/uart_ram_dumper.sv - streams a RAM word range over the UART TX handshake plus an additive checksum
module uart_ram_dumper
  import uart_pkg::*;
#(
  parameter int ADDR_LEN = 14,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                inhibit,
  input  logic [ADDR_LEN-1:0] start_addr,
  input  logic [ADDR_LEN:0]   word_count,
  output logic                busy,
  output logic                done,
  output logic                ram_rd_en,
  output logic [ADDR_LEN-1:0] ram_addr,
  input  logic [XLEN-1:0]     ram_rd_data,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_busy
);

  localparam int BYTES  = dump_bytes(XLEN);
  localparam int BIDX_W = dump_bidx_w(XLEN);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);

  dump_state_t         state, state_d;
  logic [ADDR_LEN-1:0] addr;
  logic [ADDR_LEN:0]   remain;
  logic [XLEN-1:0]     shreg;
  logic [BIDX_W-1:0]   byte_idx;
  logic [7:0]          cksum;
  logic [7:0]          tx_data_q;
  logic [7:0]          tx_byte;
  logic                cksgap_seen;
  logic                capture, load_sh, next_byte, next_word;

  // The address register doubles as the RAM address; it only moves between reads
  assign ram_addr = addr;
  assign tx_byte  = (state == DS_CKS) ? cksum : shreg[7:0];
  // Show the new byte in its launch cycle, then hold it until the next launch
  assign tx_data  = tx_valid ? tx_byte : tx_data_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= DS_IDLE;
    else     state <= state_d;
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_d   = state;
    busy      = 1'b0;
    done      = 1'b0;
    ram_rd_en = 1'b0;
    tx_valid  = 1'b0;
    capture   = 1'b0;
    load_sh   = 1'b0;
    next_byte = 1'b0;
    next_word = 1'b0;
    case (state)
      DS_IDLE: begin
        if (start && !inhibit) begin
          capture = 1'b1;
          state_d = DS_RD;
        end
      end
      DS_RD: begin
        busy = 1'b1;
        if (remain == '0) begin
          state_d = DS_CKS;
        end else begin
          ram_rd_en = 1'b1;
          state_d   = DS_RDW;
        end
      end
      DS_RDW: begin
        busy    = 1'b1;
        load_sh = 1'b1;
        state_d = DS_SEND;
      end
      DS_SEND: begin
        busy = 1'b1;
        if (!tx_busy) begin
          tx_valid = 1'b1;
          state_d  = DS_GAP;
        end
      end
      DS_GAP: begin
        busy = 1'b1;
        if (byte_idx == LAST_IDX) begin
          next_word = 1'b1;
          state_d   = DS_RD;
        end else begin
          next_byte = 1'b1;
          state_d   = DS_SEND;
        end
      end
      DS_CKS: begin
        busy = 1'b1;
        if (!tx_busy) begin
          tx_valid = 1'b1;
          state_d  = DS_CKSGAP;
        end
      end
      DS_CKSGAP: begin
        busy = 1'b1;
        if (cksgap_seen && !tx_busy) state_d = DS_DONE;
      end
      DS_DONE: begin
        done    = 1'b1;
        state_d = DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Datapath: address/count, shift register, checksum and held TX byte
  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      remain      <= '0;
      shreg       <= '0;
      byte_idx    <= '0;
      cksum       <= '0;
      tx_data_q   <= '0;
      cksgap_seen <= 1'b0;
    end else begin
      // First CKSGAP cycle ignores tx_busy, which is only just rising
      cksgap_seen <= (state == DS_CKSGAP);
      if (capture) begin
        addr   <= start_addr;
        remain <= word_count;
        cksum  <= '0;
      end
      if (load_sh) begin
        shreg    <= ram_rd_data;
        byte_idx <= '0;
      end
      if (tx_valid) begin
        tx_data_q <= tx_byte;
        if (state == DS_SEND) cksum <= cksum + tx_byte;
      end
      if (next_byte) begin
        shreg    <= shreg >> 8;
        byte_idx <= byte_idx + BIDX_W'(1);
      end
      if (next_word) begin
        addr   <= addr + ADDR_LEN'(1);
        remain <= remain - (ADDR_LEN + 1)'(1);
      end
    end
  end

endmodule

// File: doc/uart_ram_dumper.md
# uart_ram_dumper

Reads a contiguous range of RAM words and streams them out over the UART transmitter, least-significant byte first, followed by an 8-bit additive checksum. It is the readback counterpart of the UART software upgrader, so software or a host can verify an upgrade image. It sits between the RAM read port and the `uart` transmit handshake (`tx_valid`/`tx_data`/`tx_busy`), next to the TX FIFO path.

## Interface
- `ADDR_LEN`, 14: word-address width.
- `XLEN`, 32: word width; must be a multiple of 8. `BYTES = XLEN/8`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `inhibit`  in  1  while high, `start` is ignored (tied to `during_sw_upgrade`).
- `start_addr`  in  ADDR_LEN  first word address; captured with `start`.
- `word_count`  in  ADDR_LEN+1  number of words to dump; captured with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the checksum byte's handshake completes.
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_addr`  out  ADDR_LEN  RAM word address.
- `ram_rd_data`  in  XLEN  RAM read data, valid exactly 1 cycle after `ram_rd_en`.
- `tx_valid`  out  1  one-cycle byte launch pulse to the UART.
- `tx_data`  out  8  byte; held stable from the `tx_valid` cycle until the next launch.
- `tx_busy`  in  1  UART shifting; it rises the cycle after `tx_valid`.

## Operation
- States: IDLE, RD, RDW, SEND, GAP, CKS, CKSGAP, DONE.
- IDLE -> RD when `start & ~inhibit`. On that edge, capture `start_addr` into `addr`, `word_count` into `remain`, and clear `cksum`. A `start` in any other state is ignored.
- **RD**
  - If `remain == 0`, go to CKS.
  - Otherwise assert `ram_rd_en` with `ram_addr = addr`, then go to RDW.
- **RDW**
  - Load the shift register from `ram_rd_data`.
  - Set `byte_idx = 0`, then go to SEND.
- **SEND**
  - Wait until `tx_busy == 0`.
  - Then pulse `tx_valid` with `tx_data = shreg[7:0]`.
  - Update `cksum += tx_data` (mod 256), then go to GAP.
- **GAP**
  - Lasts one cycle; `tx_busy` is not sampled.
  - If `byte_idx == BYTES-1`: `addr += 1` (wraps mod 2^ADDR_LEN), `remain -= 1`, go to RD.
  - Otherwise shift `shreg` right by 8, `byte_idx += 1`, go to SEND.
- **CKS**: wait until `tx_busy == 0`, pulse `tx_valid` with `tx_data = cksum`, then go to CKSGAP.
- **CKSGAP**: one cycle, then wait until `tx_busy == 0`, then go to DONE.
- **DONE**: pulse `done` for one cycle, deassert `busy`, go to IDLE.
- `word_count == 0`: exactly one byte is sent, the checksum `0x00`.
- `word_count = 2^ADDR_LEN`: the address wraps through all words and finishes back at `start_addr`.
- The checksum covers data bytes only, not itself.
- `inhibit` rising mid-dump has no effect on a dump already in progress.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers cleared. Reset mid-dump aborts immediately with no `done` pulse; a byte already launched still completes inside the UART.
- An accepted `start` in cycle 0 gives `busy` and `ram_rd_en` in cycle 1, capture in cycle 2, and the first `tx_valid` in cycle 3 if `tx_busy` is low.
- Between bytes of the same word, the minimum `tx_valid` spacing is 2 cycles plus the UART busy time.
- Across a word boundary, 2 extra cycles are added (RD, RDW).
- `ram_rd_en` is asserted for exactly one cycle per word; `ram_addr` holds its value otherwise.
- `done` is asserted in the cycle after `tx_busy` is seen low in CKSGAP; `busy` falls in the same cycle as `done`.

## Structure
- Put the following in shared `uart_pkg`:
  - the `dump_state_t` enum;
  - `localparam` helpers for `BYTES` and the byte-index width `$clog2(BYTES)`.
- Implement as a single module with no sub-module. `uart_mgr` instantiates it and muxes `ram_addr` and `ram_rd_en` with the core's port while `busy` is high.

## Test plan
- `start_addr=0x10`, `word_count=1`, RAM[0x10]=0x44332211, UART model busy for 10 cycles per byte:
  - expected tx sequence: 11, 22, 33, 44, AA;
  - expected `done` once;
  - expected `ram_rd_en` count 1.
- `word_count=0` -> a single byte `0x00`, `done` follows, and there is no `ram_rd_en`.
- `start_addr=0x3FFF`, `word_count=2`, RAM[0x3FFF]=0x01010101, RAM[0]=0x02020202 -> reads occur at 0x3FFF then 0x0000; the bytes are 01×4, 02×4, then 0x0C.
- `start` pulsed again mid-dump and `start` with `inhibit=1` in IDLE -> both are ignored: no new capture and no change in `busy`.
- `rst` asserted during the third byte -> next cycle all outputs are 0 and the state is IDLE; a fresh `start` then dumps correctly from byte 0.
- `tx_busy` held high for 100 cycles mid-word -> `tx_valid` stays low and `tx_data` stays stable; the stream resumes with no dropped or duplicated bytes.
